// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, ALU/select bit positions and divider states
// for the execute stage.
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int STALL_BUS    = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // alu_op bit positions, add in the MSB down to lui in the LSB
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1c;
    localparam logic [5:0] FN_MFHI     = 6'h10;
    localparam logic [5:0] FN_MTHI     = 6'h11;
    localparam logic [5:0] FN_MFLO     = 6'h12;
    localparam logic [5:0] FN_MTLO     = 6'h13;
    localparam logic [5:0] FN_MULT     = 6'h18;
    localparam logic [5:0] FN_MULTU    = 6'h19;
    localparam logic [5:0] FN_DIV      = 6'h1a;
    localparam logic [5:0] FN_DIVU     = 6'h1b;
    localparam logic [5:0] FN_MUL      = 6'h02;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/ex_stage_div.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// sign fix-up applied to the registered result. busy/done expose the FSM state.
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CW = $clog2(DIV_CYCLES);

    div_state_t  state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0] quo, rem, dsr;
    logic        q_neg, r_neg;
    logic [32:0] partial, diff;
    logic [31:0] dvd_mag, dsr_mag;

    assign dvd_mag = (signed_op && dividend[31]) ? (~dividend + 32'd1) : dividend;
    assign dsr_mag = (signed_op && divisor[31])  ? (~divisor + 32'd1)  : divisor;

    assign partial = {rem, quo[31]};
    assign diff    = partial - {1'b0, dsr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DIV_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            DIV_IDLE: if (start) state_n = (divisor == 32'd0) ? DIV_DONE : DIV_RUN;
            DIV_RUN:  if (cnt == CW'(DIV_CYCLES - 1)) state_n = DIV_DONE;
            DIV_DONE: state_n = DIV_IDLE;
            default:  state_n = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dsr   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        dsr <= dsr_mag;
                        if (divisor == 32'd0) begin
                            quo   <= 32'hffff_ffff;
                            rem   <= dividend;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                        end else begin
                            quo   <= dvd_mag;
                            rem   <= '0;
                            q_neg <= signed_op & (dividend[31] ^ divisor[31]);
                            r_neg <= signed_op & dividend[31];
                        end
                    end
                end
                DIV_RUN: begin
                    cnt <= cnt + CW'(1);
                    quo <= {quo[30:0], ~diff[32]};
                    rem <= diff[32] ? partial[31:0] : diff[31:0];
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == DIV_RUN);
    assign done      = (state == DIV_DONE);
    assign quotient  = q_neg ? (~quo + 32'd1) : quo;
    assign remainder = r_neg ? (~rem + 32'd1) : rem;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: decode-to-execute register, ALU, HI/LO with multiply and
// iterative divide, data SRAM request and the execute-to-memory bus.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic                    stallreq_for_ex,
    output logic                    ex_we,
    output logic [4:0]              ex_waddr,
    output logic [31:0]             ex_wdata,
    output logic [4:0]              ex_ram_ctrl,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus
);

    logic [ID_TO_EX_WD-1:0] bus_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                      bus_r <= '0;
        else if (stall[2] == STOP && stall[3] == NO_STOP) bus_r <= '0;
        else if (stall[2] == NO_STOP)                  bus_r <= id_to_ex_bus;
    end

    logic [31:0] pc, inst, rs_val, rt_val;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en, rf_we, sel_rf_res;
    logic [3:0]  ram_wen;
    logic [4:0]  rf_waddr;

    assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
            rf_we, rf_waddr, sel_rf_res, rs_val, rt_val} = bus_r;

    logic unused_bits;
    assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16]};

    logic leave;
    assign leave = (stall[2] == NO_STOP);

    logic [5:0] opcode, funct;
    logic is_mfhi, is_mflo, is_mthi, is_mtlo, is_mult, is_multu, is_mul, is_divs, is_divu, is_div;
    assign opcode   = inst[31:26];
    assign funct    = inst[5:0];
    assign is_mfhi  = (opcode == OP_SPECIAL)  && (funct == FN_MFHI);
    assign is_mthi  = (opcode == OP_SPECIAL)  && (funct == FN_MTHI);
    assign is_mflo  = (opcode == OP_SPECIAL)  && (funct == FN_MFLO);
    assign is_mtlo  = (opcode == OP_SPECIAL)  && (funct == FN_MTLO);
    assign is_mult  = (opcode == OP_SPECIAL)  && (funct == FN_MULT);
    assign is_multu = (opcode == OP_SPECIAL)  && (funct == FN_MULTU);
    assign is_divs  = (opcode == OP_SPECIAL)  && (funct == FN_DIV);
    assign is_divu  = (opcode == OP_SPECIAL)  && (funct == FN_DIVU);
    assign is_mul   = (opcode == OP_SPECIAL2) && (funct == FN_MUL);
    assign is_div   = is_divs | is_divu;

    logic [31:0] src1, src2, imm_sx, imm_zx;
    assign imm_sx = {{16{inst[15]}}, inst[15:0]};
    assign imm_zx = {16'b0, inst[15:0]};
    assign src1 = ({32{sel_src1[0]}} & rs_val)
                | ({32{sel_src1[1]}} & pc)
                | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
    assign src2 = ({32{sel_src2[0]}} & rt_val)
                | ({32{sel_src2[1]}} & imm_sx)
                | ({32{sel_src2[2]}} & 32'd8)
                | ({32{sel_src2[3]}} & imm_zx);

    logic [4:0]  sh;
    logic [31:0] sra_res, alu_res;
    assign sh      = src1[4:0];
    assign sra_res = $signed(src2) >>> sh;
    assign alu_res = ({32{alu_op[ALU_ADD]}}  & (src1 + src2))
                   | ({32{alu_op[ALU_SUB]}}  & (src1 - src2))
                   | ({32{alu_op[ALU_SLT]}}  & {31'b0, $signed(src1) < $signed(src2)})
                   | ({32{alu_op[ALU_SLTU]}} & {31'b0, src1 < src2})
                   | ({32{alu_op[ALU_AND]}}  & (src1 & src2))
                   | ({32{alu_op[ALU_NOR]}}  & ~(src1 | src2))
                   | ({32{alu_op[ALU_OR]}}   & (src1 | src2))
                   | ({32{alu_op[ALU_XOR]}}  & (src1 ^ src2))
                   | ({32{alu_op[ALU_SLL]}}  & (src2 << sh))
                   | ({32{alu_op[ALU_SRL]}}  & (src2 >> sh))
                   | ({32{alu_op[ALU_SRA]}}  & sra_res)
                   | ({32{alu_op[ALU_LUI]}}  & {src2[15:0], 16'b0});

    logic [63:0] rs_sx, rt_sx, prod_s, prod_u;
    assign rs_sx  = {{32{rs_val[31]}}, rs_val};
    assign rt_sx  = {{32{rt_val[31]}}, rt_val};
    assign prod_s = rs_sx * rt_sx;
    assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

    logic        div_busy, div_done, div_complete, div_start;
    logic [31:0] div_q, div_r;

    // A finished divide held by a downstream stall must not restart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          div_complete <= 1'b0;
        else if (leave)    div_complete <= 1'b0;
        else if (div_done) div_complete <= 1'b1;
    end

    assign div_start       = is_div & ~div_busy & ~div_done & ~div_complete;
    assign stallreq_for_ex = is_div & ~div_done & ~div_complete;

    div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .signed_op (is_divs),
        .dividend  (rs_val),
        .divisor   (rt_val),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    logic [31:0] hi, lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (leave) begin
            if (is_mult)                               {hi, lo} <= prod_s;
            else if (is_multu)                         {hi, lo} <= prod_u;
            else if (is_mthi)                          hi <= rs_val;
            else if (is_mtlo)                          lo <= rs_val;
            else if (is_div && (div_done || div_complete)) {hi, lo} <= {div_r, div_q};
        end
    end

    logic [31:0] ex_result;
    always_comb begin
        ex_result = alu_res;
        if (is_mfhi)      ex_result = hi;
        else if (is_mflo) ex_result = lo;
        else if (is_mul)  ex_result = prod_s[31:0];
    end

    always_comb begin
        data_sram_wen   = 4'b0000;
        data_sram_wdata = 32'd0;
        if (ram_en) begin
            if (ram_wen[0]) begin
                data_sram_wen   = 4'b1111;
                data_sram_wdata = rt_val;
            end else if (ram_wen[1]) begin
                data_sram_wen   = 4'b0011 << {ex_result[1], 1'b0};
                data_sram_wdata = {2{rt_val[15:0]}};
            end else if (ram_wen[2]) begin
                data_sram_wen   = 4'b0001 << ex_result[1:0];
                data_sram_wdata = {4{rt_val[7:0]}};
            end
        end
    end

    assign data_sram_en   = ram_en;
    assign data_sram_addr = ex_result;
    assign ex_ram_ctrl    = {ram_en, ram_wen};
    assign ex_we          = rf_we;
    assign ex_waddr       = rf_waddr;
    assign ex_wdata       = ex_result;
    assign ex_to_mem_bus  = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: the driver pushes hand-computed expectations,
// a negedge monitor pops one whenever an instruction leaves execute.
module tb_ex_stage;

    localparam int EXP_W = 188;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall, stall_force;
    logic [158:0] id_bus;
    logic         stallreq_for_ex, ex_we, data_sram_en;
    logic [4:0]   ex_waddr, ex_ram_ctrl;
    logic [31:0]  ex_wdata, data_sram_addr, data_sram_wdata;
    logic [3:0]   data_sram_wen;
    logic [75:0]  ex_to_mem_bus;
    logic         ex_valid;

    int n_tests = 0;
    int n_fail  = 0;
    logic [EXP_W-1:0] exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    // Stall controller stand-in: the divider freezes stages 0..3.
    assign stall = stallreq_for_ex ? 6'b001111 : stall_force;

    ex_stage #(.DIV_CYCLES(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_bus),
        .stallreq_for_ex (stallreq_for_ex),
        .ex_we           (ex_we),
        .ex_waddr        (ex_waddr),
        .ex_wdata        (ex_wdata),
        .ex_ram_ctrl     (ex_ram_ctrl),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .ex_to_mem_bus   (ex_to_mem_bus)
    );

    // Tracks whether a real instruction sits in execute.
    always @(posedge clk or negedge rst) begin
        if (!rst)           ex_valid <= 1'b0;
        else if (!stall[2]) ex_valid <= (id_bus != '0);
        else if (!stall[3]) ex_valid <= 1'b0;
    end

    function automatic logic [158:0] mk_bus(
        input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] aop,
        input logic [2:0] s1, input logic [3:0] s2, input logic ren, input logic [3:0] rwen,
        input logic we, input logic [4:0] wa, input logic srr,
        input logic [31:0] rs, input logic [31:0] rt);
        return {pc, inst, aop, s1, s2, ren, rwen, we, wa, srr, rs, rt};
    endfunction

    function automatic logic [EXP_W-1:0] mk_exp(
        input logic [31:0] pc, input logic ren, input logic [3:0] rwen, input logic srr,
        input logic we, input logic [4:0] wa, input logic [31:0] res,
        input logic [3:0] swen, input logic [31:0] sdata);
        return {pc, ren, rwen, srr, we, wa, res, we, wa, res, ren, rwen, ren, swen, res, sdata};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [158:0] b, input logic [EXP_W-1:0] e, input string nm);
        int guard = 0;
        while (stall[2] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: issue timeout, stall[2] still %b", nm, stall[2]);
        end
        id_bus = b;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        id_bus = '0;
    endtask

    task automatic md(input logic [31:0] pc, input logic [5:0] fn, input logic [31:0] rs,
                      input logic [31:0] rt, input logic we, input logic [4:0] wa,
                      input logic [31:0] res, input string nm);
        logic [31:0] inst;
        inst = {6'd0, 20'd0, fn};
        issue(mk_bus(pc, inst, 12'h0, 3'b0, 4'b0, 1'b0, 4'b0, we, wa, 1'b0, rs, rt),
              mk_exp(pc, 1'b0, 4'b0, 1'b0, we, wa, res, 4'b0, 32'd0), nm);
    endtask

    task automatic div_wait(input int exp_cycles, input string nm);
        int cnt = 0;
        while (stallreq_for_ex && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk(nm, 64'(cnt), 64'(exp_cycles));
    endtask

    always @(negedge clk) begin
        if (rst && ex_valid && !stall[2]) begin
            logic [EXP_W-1:0] act, exp;
            string nm;
            act = {ex_to_mem_bus, ex_we, ex_waddr, ex_wdata, ex_ram_ctrl,
                   data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata};
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got %h with no expectation queued", act);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", nm, act, exp);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        stall_force = 6'b0;
        id_bus = '0;
        repeat (3) @(negedge clk);
        chk("reset_stallreq", 64'(stallreq_for_ex), 64'd0);
        chk("reset_bus", 64'(ex_to_mem_bus[63:0]), 64'd0);
        chk("reset_sram", 64'({data_sram_en, data_sram_wen, data_sram_addr}), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // ALU
        issue(mk_bus(32'h100, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 12'h800, 3'b001, 4'b0001,
                     1'b0, 4'b0, 1'b1, 5'd3, 1'b0, 32'd5, 32'd7),
              mk_exp(32'h100, 1'b0, 4'b0, 1'b0, 1'b1, 5'd3, 32'd12, 4'b0, 32'd0), "addu");
        issue(mk_bus(32'h104, {6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'h23}, 12'h400, 3'b001, 4'b0001,
                     1'b0, 4'b0, 1'b1, 5'd4, 1'b0, 32'd5, 32'd7),
              mk_exp(32'h104, 1'b0, 4'b0, 1'b0, 1'b1, 5'd4, 32'hffff_fffe, 4'b0, 32'd0), "subu");
        issue(mk_bus(32'h108, {6'd0, 5'd1, 5'd2, 5'd5, 5'd0, 6'h2a}, 12'h200, 3'b001, 4'b0001,
                     1'b0, 4'b0, 1'b1, 5'd5, 1'b0, 32'hffff_ffff, 32'd1),
              mk_exp(32'h108, 1'b0, 4'b0, 1'b0, 1'b1, 5'd5, 32'd1, 4'b0, 32'd0), "slt");
        issue(mk_bus(32'h10c, {6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'h2b}, 12'h100, 3'b001, 4'b0001,
                     1'b0, 4'b0, 1'b1, 5'd6, 1'b0, 32'hffff_ffff, 32'd1),
              mk_exp(32'h10c, 1'b0, 4'b0, 1'b0, 1'b1, 5'd6, 32'd0, 4'b0, 32'd0), "sltu");
        issue(mk_bus(32'h110, {6'd0, 5'd0, 5'd2, 5'd7, 5'd4, 6'h00}, 12'h008, 3'b100, 4'b0001,
                     1'b0, 4'b0, 1'b1, 5'd7, 1'b0, 32'd0, 32'd3),
              mk_exp(32'h110, 1'b0, 4'b0, 1'b0, 1'b1, 5'd7, 32'h30, 4'b0, 32'd0), "sll");
        issue(mk_bus(32'h114, {6'd0, 5'd0, 5'd2, 5'd7, 5'd4, 6'h03}, 12'h002, 3'b100, 4'b0001,
                     1'b0, 4'b0, 1'b1, 5'd7, 1'b0, 32'd0, 32'h8000_0000),
              mk_exp(32'h114, 1'b0, 4'b0, 1'b0, 1'b1, 5'd7, 32'hf800_0000, 4'b0, 32'd0), "sra");
        issue(mk_bus(32'h118, {6'h0f, 5'd0, 5'd2, 16'h1234}, 12'h001, 3'b000, 4'b1000,
                     1'b0, 4'b0, 1'b1, 5'd2, 1'b0, 32'd0, 32'd0),
              mk_exp(32'h118, 1'b0, 4'b0, 1'b0, 1'b1, 5'd2, 32'h1234_0000, 4'b0, 32'd0), "lui");
        issue(mk_bus(32'h11c, {6'd0, 5'd1, 5'd2, 5'd8, 5'd0, 6'h27}, 12'h040, 3'b001, 4'b0001,
                     1'b0, 4'b0, 1'b1, 5'd8, 1'b0, 32'h0f0f_0000, 32'h00ff_0000),
              mk_exp(32'h11c, 1'b0, 4'b0, 1'b0, 1'b1, 5'd8, 32'hf000_ffff, 4'b0, 32'd0), "nor");
        issue(mk_bus(32'h400, {6'h03, 26'd0}, 12'h800, 3'b010, 4'b0100,
                     1'b0, 4'b0, 1'b1, 5'd31, 1'b0, 32'd0, 32'd0),
              mk_exp(32'h400, 1'b0, 4'b0, 1'b0, 1'b1, 5'd31, 32'h408, 4'b0, 32'd0), "link_pc8");

        // Memory requests
        issue(mk_bus(32'h120, {6'h28, 5'd1, 5'd2, 16'h0003}, 12'h800, 3'b001, 4'b0010,
                     1'b1, 4'b0100, 1'b0, 5'd0, 1'b0, 32'h1000, 32'h0000_00ab),
              mk_exp(32'h120, 1'b1, 4'b0100, 1'b0, 1'b0, 5'd0, 32'h1003, 4'b1000, 32'habab_abab), "sb");
        issue(mk_bus(32'h124, {6'h29, 5'd1, 5'd2, 16'h0002}, 12'h800, 3'b001, 4'b0010,
                     1'b1, 4'b0010, 1'b0, 5'd0, 1'b0, 32'h1000, 32'h1234_abcd),
              mk_exp(32'h124, 1'b1, 4'b0010, 1'b0, 1'b0, 5'd0, 32'h1002, 4'b1100, 32'habcd_abcd), "sh");
        issue(mk_bus(32'h128, {6'h2b, 5'd1, 5'd2, 16'hfffc}, 12'h800, 3'b001, 4'b0010,
                     1'b1, 4'b0001, 1'b0, 5'd0, 1'b0, 32'h1000, 32'hdead_beef),
              mk_exp(32'h128, 1'b1, 4'b0001, 1'b0, 1'b0, 5'd0, 32'h0ffc, 4'b1111, 32'hdead_beef), "sw");
        issue(mk_bus(32'h12c, {6'h23, 5'd1, 5'd5, 16'h0008}, 12'h800, 3'b001, 4'b0010,
                     1'b1, 4'b0000, 1'b1, 5'd5, 1'b1, 32'h2000, 32'd0),
              mk_exp(32'h12c, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd5, 32'h2008, 4'b0000, 32'd0), "lw");

        // Divides
        md(32'h200, 6'h1b, 32'd100, 32'd7, 1'b0, 5'd0, 32'd0, "divu_100_7");
        div_wait(33, "divu_stall_cycles");
        md(32'h204, 6'h12, 32'd0, 32'd0, 1'b1, 5'd8, 32'd14, "divu_mflo");
        md(32'h208, 6'h10, 32'd0, 32'd0, 1'b1, 5'd9, 32'd2, "divu_mfhi");
        md(32'h20c, 6'h1a, 32'hffff_fff9, 32'd2, 1'b0, 5'd0, 32'd0, "div_m7_2");
        div_wait(33, "div_stall_cycles");
        md(32'h210, 6'h12, 32'd0, 32'd0, 1'b1, 5'd8, 32'hffff_fffd, "div_mflo");
        md(32'h214, 6'h10, 32'd0, 32'd0, 1'b1, 5'd9, 32'hffff_ffff, "div_mfhi");
        md(32'h218, 6'h1a, 32'd9, 32'd0, 1'b0, 5'd0, 32'd0, "div_by_zero");
        div_wait(1, "div0_stall_cycles");
        md(32'h21c, 6'h12, 32'd0, 32'd0, 1'b1, 5'd8, 32'hffff_ffff, "div0_mflo");
        md(32'h220, 6'h10, 32'd0, 32'd0, 1'b1, 5'd9, 32'd9, "div0_mfhi");

        // Multiplies and moves
        md(32'h300, 6'h18, 32'hffff_ffff, 32'd2, 1'b0, 5'd0, 32'd0, "mult");
        md(32'h304, 6'h10, 32'd0, 32'd0, 1'b1, 5'd9, 32'hffff_ffff, "mult_mfhi");
        md(32'h308, 6'h12, 32'd0, 32'd0, 1'b1, 5'd8, 32'hffff_fffe, "mult_mflo");
        md(32'h30c, 6'h19, 32'hffff_ffff, 32'd2, 1'b0, 5'd0, 32'd0, "multu");
        md(32'h310, 6'h10, 32'd0, 32'd0, 1'b1, 5'd9, 32'd1, "multu_mfhi");
        md(32'h314, 6'h12, 32'd0, 32'd0, 1'b1, 5'd8, 32'hffff_fffe, "multu_mflo");
        issue(mk_bus(32'h318, {6'h1c, 20'd0, 6'h02}, 12'h0, 3'b0, 4'b0, 1'b0, 4'b0,
                     1'b1, 5'd10, 1'b0, 32'hffff_fffd, 32'd5),
              mk_exp(32'h318, 1'b0, 4'b0, 1'b0, 1'b1, 5'd10, 32'hffff_fff1, 4'b0, 32'd0), "mul");
        md(32'h31c, 6'h11, 32'h55, 32'd0, 1'b0, 5'd0, 32'd0, "mthi");
        md(32'h320, 6'h10, 32'd0, 32'd0, 1'b1, 5'd9, 32'h55, "mthi_mfhi");

        // Hold a mult, then squash it with a bubble: HI must keep 0x55
        id_bus = mk_bus(32'h500, {6'd0, 20'd0, 6'h18}, 12'h0, 3'b0, 4'b0, 1'b0, 4'b0,
                        1'b0, 5'd0, 1'b0, 32'hffff_ffff, 32'd2);
        @(posedge clk);
        #1 stall_force = 6'b001100;
        id_bus = '0;
        repeat (3) @(negedge clk);
        chk("hold_pc", 64'(ex_to_mem_bus[75:44]), 64'h500);
        @(posedge clk);
        #1 stall_force = 6'b000111;
        @(posedge clk);
        #1 stall_force = 6'b000000;
        @(negedge clk);
        chk("bubble_bus", 64'(ex_to_mem_bus[63:0]), 64'd0);
        chk("bubble_fwd", 64'({ex_we, ex_waddr, ex_wdata}), 64'd0);
        chk("bubble_sram", 64'({data_sram_en, data_sram_wen, data_sram_wdata}), 64'd0);
        md(32'h504, 6'h10, 32'd0, 32'd0, 1'b1, 5'd9, 32'h55, "held_mult_no_hi_write");

        // Asynchronous reset in the middle of a divide
        id_bus = mk_bus(32'h600, {6'd0, 20'd0, 6'h1b}, 12'h0, 3'b0, 4'b0, 1'b0, 4'b0,
                        1'b0, 5'd0, 1'b0, 32'd1000, 32'd3);
        @(negedge clk);
        id_bus = '0;
        repeat (11) @(negedge clk);
        chk("mid_div_stallreq", 64'(stallreq_for_ex), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst_stallreq", 64'(stallreq_for_ex), 64'd0);
        chk("rst_bus", 64'(ex_to_mem_bus[75:12]), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        md(32'h604, 6'h10, 32'd0, 32'd0, 1'b1, 5'd9, 32'd0, "rst_mfhi");
        md(32'h608, 6'h12, 32'd0, 32'd0, 1'b1, 5'd8, 32'd0, "rst_mflo");
        md(32'h60c, 6'h1b, 32'd100, 32'd7, 1'b0, 5'd0, 32'd0, "post_rst_divu");
        div_wait(33, "post_rst_stall_cycles");
        md(32'h610, 6'h12, 32'd0, 32'd0, 1'b1, 5'd8, 32'd14, "post_rst_mflo");

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
